// File: rtl/obstacle_scroller_pkg.sv
// Shared playfield constants, the obstacle slot record and a height clamp helper.
package obstacle_scroller_pkg;
  localparam int unsigned COORD_W      = 10;
  localparam int unsigned XW           = 11;
  localparam int unsigned CNT_W        = 4;
  localparam int unsigned DEF_SCREEN_W = 640;
  localparam int unsigned DEF_GROUND_Y = 400;

  typedef struct packed {
    logic               valid;
    logic [XW-1:0]      x;
    logic [COORD_W-1:0] h;
  } slot_t;

  function automatic logic [COORD_W-1:0] clamp_h(input logic [COORD_W-1:0] amp,
                                                 input logic [COORD_W-1:0] lim);
    return (amp > lim) ? lim : amp;
  endfunction
endpackage

// File: rtl/obstacle_scroller_if.sv
// Game-side signal bundle between the game logic/renderer and the obstacle scroller.
interface obstacle_scroller_if;
  import obstacle_scroller_pkg::*;

  logic               game_en;
  logic               game_run;
  logic [COORD_W-1:0] rand_amp;
  logic [COORD_W-1:0] pixel_x;
  logic [COORD_W-1:0] pixel_y;
  logic [COORD_W-1:0] player_y;
  logic               clear_collision;
  logic               obstacle_pixel;
  logic               collision;
  logic               spawn_pulse;
  logic [CNT_W-1:0]   active_count;

  modport master (
    output game_en, game_run, rand_amp, pixel_x, pixel_y, player_y, clear_collision,
    input  obstacle_pixel, collision, spawn_pulse, active_count
  );

  modport slave (
    input  game_en, game_run, rand_amp, pixel_x, pixel_y, player_y, clear_collision,
    output obstacle_pixel, collision, spawn_pulse, active_count
  );
endinterface

// File: rtl/obstacle_slot_hit.sv
// Combinational test: does a query rectangle (a single pixel, or the player box)
// overlap one obstacle slot standing on the ground line.
module obstacle_slot_hit
  import obstacle_scroller_pkg::*;
#(
  parameter int unsigned GROUND_Y = DEF_GROUND_Y,
  parameter int unsigned OBS_W    = 20,
  parameter bit          IS_BOX   = 1'b0,
  parameter int unsigned BOX_W    = 1,
  parameter int unsigned BOX_H    = 1
) (
  input  slot_t         slot_i,
  input  logic [XW-1:0] qx_i,
  input  logic [XW-1:0] qy_i,
  output logic          hit_c_o
);
  localparam int unsigned QW = IS_BOX ? BOX_W : 1;
  localparam int unsigned QH = IS_BOX ? BOX_H : 1;

  logic [XW-1:0] obs_right;
  logic [XW-1:0] obs_top;
  logic [XW-1:0] q_right;
  logic [XW-1:0] q_bottom;

  assign obs_right = slot_i.x + XW'(OBS_W);
  assign obs_top   = XW'(GROUND_Y) - XW'(slot_i.h);
  assign q_right   = qx_i + XW'(QW);
  assign q_bottom  = qy_i + XW'(QH);

  // Zero-height obstacles are empty rectangles and never overlap anything.
  assign hit_c_o = slot_i.valid && (slot_i.h != '0) &&
                   (qx_i < obs_right) && (slot_i.x < q_right) &&
                   (qy_i < XW'(GROUND_Y)) && (obs_top < q_bottom);
endmodule

// File: rtl/obstacle_scroller.sv
// Pool of ground obstacles scrolling right-to-left; spawns on game ticks and
// answers pixel-hit and player-collision queries.
module obstacle_scroller
  import obstacle_scroller_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 4,
  parameter int unsigned SCREEN_W  = DEF_SCREEN_W,
  parameter int unsigned GROUND_Y  = DEF_GROUND_Y,
  parameter int unsigned OBS_W     = 20,
  parameter int unsigned SPEED     = 4,
  parameter int unsigned SPAWN_GAP = 160,
  parameter int unsigned PLAYER_X  = 80,
  parameter int unsigned PLAYER_W  = 16,
  parameter int unsigned PLAYER_H  = 16
) (
  input  logic                clk,
  input  logic                rst,
  obstacle_scroller_if.slave  bus
);
  localparam int unsigned GAP_W = $clog2(SPAWN_GAP + SPEED + 1);

  slot_t [NUM_SLOTS-1:0] slots_q, slots_d;
  logic [GAP_W-1:0]      gap_q, gap_d, gap_sum;
  logic [NUM_SLOTS-1:0]  free_sel;
  logic [NUM_SLOTS-1:0]  pix_hit, box_hit;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  spawn_q, spawn_d;
  logic                  pix_q, collision_q;
  logic                  tick;
  slot_t                 new_slot;

  assign tick     = bus.game_en & bus.game_run;
  assign new_slot = '{valid: 1'b1, x: XW'(SCREEN_W),
                      h: clamp_h(bus.rand_amp, COORD_W'(GROUND_Y))};

  // Lowest-index slot that is free before this tick's moves.
  always_comb begin : p_free
    logic found;
    found    = 1'b0;
    free_sel = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (!slots_q[i].valid && !found) begin
        free_sel[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

  always_comb begin
    slots_d = slots_q;
    gap_d   = gap_q;
    spawn_d = 1'b0;
    count_d = '0;
    gap_sum = gap_q + GAP_W'(SPEED);
    if (tick) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (slots_q[i].valid) begin
          if (slots_q[i].x < XW'(SPEED)) slots_d[i].valid = 1'b0;
          else                           slots_d[i].x     = slots_q[i].x - XW'(SPEED);
        end
      end
      // Saturate so a spawn deferred by a full pool fires on the first free tick.
      gap_d = (gap_sum > GAP_W'(SPAWN_GAP)) ? GAP_W'(SPAWN_GAP) : gap_sum;
      if ((gap_d == GAP_W'(SPAWN_GAP)) && (free_sel != '0)) begin
        spawn_d = 1'b1;
        gap_d   = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (free_sel[i]) slots_d[i] = new_slot;
        end
      end
    end
    for (int i = 0; i < NUM_SLOTS; i++) count_d = count_d + CNT_W'(slots_d[i].valid);
  end

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_hit
    obstacle_slot_hit #(
      .GROUND_Y(GROUND_Y), .OBS_W(OBS_W), .IS_BOX(1'b0), .BOX_W(1), .BOX_H(1)
    ) u_pix (
      .slot_i (slots_q[g]),
      .qx_i   (XW'(bus.pixel_x)),
      .qy_i   (XW'(bus.pixel_y)),
      .hit_c_o(pix_hit[g])
    );
    obstacle_slot_hit #(
      .GROUND_Y(GROUND_Y), .OBS_W(OBS_W), .IS_BOX(1'b1), .BOX_W(PLAYER_W), .BOX_H(PLAYER_H)
    ) u_box (
      .slot_i (slots_q[g]),
      .qx_i   (XW'(PLAYER_X)),
      .qy_i   (XW'(bus.player_y)),
      .hit_c_o(box_hit[g])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slots_q     <= '0;
      gap_q       <= '0;
      count_q     <= '0;
      spawn_q     <= 1'b0;
      pix_q       <= 1'b0;
      collision_q <= 1'b0;
    end else begin
      slots_q     <= slots_d;
      gap_q       <= gap_d;
      count_q     <= count_d;
      spawn_q     <= spawn_d;
      pix_q       <= |pix_hit;
      // A fresh overlap beats a simultaneous clear.
      collision_q <= (|box_hit) | (collision_q & ~bus.clear_collision);
    end
  end

  assign bus.obstacle_pixel = pix_q;
  assign bus.collision      = collision_q;
  assign bus.spawn_pulse    = spawn_q;
  assign bus.active_count   = count_q;
endmodule

// File: tb/tb_obstacle_scroller.sv
// Directed bench for obstacle_scroller: a default-parameter instance plus a
// SPAWN_GAP=40 instance for the pool-full deferral scenario.
module tb_obstacle_scroller;
  logic clk;
  logic rst;
  logic rst2;
  int   checks = 0;
  int   errors = 0;

  obstacle_scroller_if bus ();
  obstacle_scroller_if bus2 ();

  assign bus2.game_en         = bus.game_en;
  assign bus2.game_run        = bus.game_run;
  assign bus2.rand_amp        = bus.rand_amp;
  assign bus2.pixel_x         = bus.pixel_x;
  assign bus2.pixel_y         = bus.pixel_y;
  assign bus2.player_y        = bus.player_y;
  assign bus2.clear_collision = bus.clear_collision;

  obstacle_scroller dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  obstacle_scroller #(.SPAWN_GAP(40)) dut2 (
    .clk(clk),
    .rst(rst2),
    .bus(bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_ticks(input int n);
    bus.game_en  = 1'b1;
    bus.game_run = 1'b1;
    repeat (n) @(negedge clk);
    bus.game_en  = 1'b0;
  endtask

  task automatic query(input string tag, input int x, input int y, input logic exp);
    bus.pixel_x = 10'(x);
    bus.pixel_y = 10'(y);
    @(negedge clk);
    check(tag, 16'(bus.obstacle_pixel), 16'(exp));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst                 = 1'b1;
    rst2                = 1'b1;
    bus.game_en         = 1'b0;
    bus.game_run        = 1'b1;
    bus.rand_amp        = 10'd37;
    bus.pixel_x         = 10'd0;
    bus.pixel_y         = 10'd0;
    bus.player_y        = 10'd500;
    bus.clear_collision = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_pixel", 16'(bus.obstacle_pixel), 16'd0);
    check("rst_coll",  16'(bus.collision),      16'd0);
    check("rst_spawn", 16'(bus.spawn_pulse),    16'd0);
    check("rst_count", 16'(bus.active_count),   16'd0);

    // First spawn needs 40 ticks; frozen game_en pulses must not count.
    run_ticks(20);
    bus.game_en  = 1'b1;
    bus.game_run = 1'b0;
    repeat (30) @(negedge clk);
    bus.game_en  = 1'b0;
    bus.game_run = 1'b1;
    check("freeze_count", 16'(bus.active_count), 16'd0);
    check("freeze_spawn", 16'(bus.spawn_pulse),  16'd0);
    run_ticks(19);
    check("t39_spawn", 16'(bus.spawn_pulse),  16'd0);
    check("t39_count", 16'(bus.active_count), 16'd0);
    run_ticks(1);
    check("t40_spawn", 16'(bus.spawn_pulse),  16'd1);
    check("t40_count", 16'(bus.active_count), 16'd1);
    query("h37_top",    640, 363, 1'b1);
    check("spawn_once", 16'(bus.spawn_pulse), 16'd0);
    query("h37_above",  640, 362, 1'b0);
    query("h37_right",  659, 399, 1'b1);
    query("h37_past",   660, 399, 1'b0);

    // Oversized amplitude clamps to the full ground height.
    do_reset();
    bus.rand_amp = 10'd700;
    run_ticks(40);
    check("clamp_spawn", 16'(bus.spawn_pulse), 16'd1);
    query("clamp_row0",   645, 0,   1'b1);
    query("clamp_row399", 645, 399, 1'b1);

    // h=50 obstacle scrolled to x=80 after 180 ticks total.
    do_reset();
    bus.rand_amp = 10'd50;
    run_ticks(180);
    check("scroll_count", 16'(bus.active_count), 16'd4);
    query("q85_355", 85,  355, 1'b1);
    query("q85_349", 85,  349, 1'b0);
    query("q100_355", 100, 355, 1'b0);
    query("q80_399", 80,  399, 1'b1);
    query("q79_399", 79,  399, 1'b0);

    bus.player_y = 10'd330;
    @(negedge clk);
    check("coll_edge_miss", 16'(bus.collision), 16'd0);
    bus.player_y        = 10'd335;
    bus.clear_collision = 1'b1;
    @(negedge clk);
    bus.clear_collision = 1'b0;
    check("coll_set_wins", 16'(bus.collision), 16'd1);
    run_ticks(10);
    bus.player_y = 10'd500;
    @(negedge clk);
    check("coll_sticky", 16'(bus.collision), 16'd1);
    bus.clear_collision = 1'b1;
    @(negedge clk);
    bus.clear_collision = 1'b0;
    check("coll_clear", 16'(bus.collision), 16'd0);

    // Frozen run: slot0 stays at x=40.
    bus.game_en  = 1'b1;
    bus.game_run = 1'b0;
    repeat (20) @(negedge clk);
    bus.game_en  = 1'b0;
    bus.game_run = 1'b1;
    check("hold_count", 16'(bus.active_count), 16'd4);
    query("hold_x40", 40, 355, 1'b1);
    query("hold_x39", 39, 355, 1'b0);

    // Default pool fills: spawn due at tick 200 waits for slot0 to retire at 201.
    run_ticks(9);
    check("t199_count", 16'(bus.active_count), 16'd4);
    run_ticks(1);
    check("t200_spawn", 16'(bus.spawn_pulse),  16'd0);
    check("t200_count", 16'(bus.active_count), 16'd4);
    run_ticks(1);
    check("t201_spawn", 16'(bus.spawn_pulse),  16'd0);
    check("t201_count", 16'(bus.active_count), 16'd3);
    run_ticks(1);
    check("t202_spawn", 16'(bus.spawn_pulse),  16'd1);
    check("t202_count", 16'(bus.active_count), 16'd4);

    // Reset mid-scroll while a tick and a pixel hit are pending.
    bus.pixel_x  = 10'd640;
    bus.pixel_y  = 10'd399;
    bus.game_en  = 1'b1;
    bus.game_run = 1'b1;
    rst          = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    bus.game_en = 1'b0;
    check("mid_rst_pixel", 16'(bus.obstacle_pixel), 16'd0);
    check("mid_rst_spawn", 16'(bus.spawn_pulse),    16'd0);
    check("mid_rst_count", 16'(bus.active_count),   16'd0);
    run_ticks(39);
    check("rst_t39_count", 16'(bus.active_count), 16'd0);
    run_ticks(1);
    check("rst_t40_spawn", 16'(bus.spawn_pulse), 16'd1);

    // SPAWN_GAP=40 instance: spawns every 10 ticks, full after 4.
    rst2         = 1'b0;
    bus.rand_amp = 10'd100;
    check("p_rst_count", 16'(bus2.active_count), 16'd0);
    run_ticks(9);
    check("p_t9_count", 16'(bus2.active_count), 16'd0);
    run_ticks(1);
    check("p_t10_spawn", 16'(bus2.spawn_pulse), 16'd1);
    run_ticks(30);
    check("p_t40_spawn", 16'(bus2.spawn_pulse),  16'd1);
    check("p_t40_count", 16'(bus2.active_count), 16'd4);
    run_ticks(10);
    check("p_t50_spawn", 16'(bus2.spawn_pulse),  16'd0);
    run_ticks(120);
    check("p_t170_count", 16'(bus2.active_count), 16'd4);
    run_ticks(1);
    check("p_t171_count", 16'(bus2.active_count), 16'd3);
    check("p_t171_spawn", 16'(bus2.spawn_pulse),  16'd0);
    run_ticks(1);
    check("p_t172_spawn", 16'(bus2.spawn_pulse),  16'd1);
    check("p_t172_count", 16'(bus2.active_count), 16'd4);
    bus.pixel_x = 10'd640;
    bus.pixel_y = 10'd399;
    @(negedge clk);
    check("p_new_x640", 16'(bus2.obstacle_pixel), 16'd1);
    run_ticks(9);
    check("p_t181_count", 16'(bus2.active_count), 16'd3);
    check("p_t181_spawn", 16'(bus2.spawn_pulse),  16'd0);
    run_ticks(1);
    check("p_t182_spawn", 16'(bus2.spawn_pulse),  16'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
